sh_mem_rr: RTL and testbench

Parametrised multi-bank shared scratchpad between the cores and the display path. It generalises the fixed core/bank shared memory to arbitrary core count, bank count and widths. Each bank has a fair round-robin arbiter with explicit per-core read-in-flight tracking. A built-in dump engine streams the whole memory image out linearly for the VGA/scheduler side.

---
 rtl/sh_mem_rr.sv | 172 +++++++++++++++++
 tb/tb_sh_mem_rr.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh_mem_rr.sv
// sh_mem_rr: multi-bank shared scratchpad with one round-robin arbiter per bank
// and a linear dump engine that streams the whole image to the display side.
//
// Ports
//   clk_i          clock, all state on rising edge
//   reset_i        asynchronous active-high reset
//   enable_i       per core {wr, rd}: 00 idle, 01 read, 10/11 write
//   addr_i         per core {bank id, word address}
//   wr_data_i      per core write data
//   rd_data_o      per core read data, zero unless that core's read completes now
//   ready_o        per core completion strobe
//   dump_start_i   starts a full-memory dump when idle
//   dump_busy_o    dump in progress (SCAN or FLUSH)
//   dump_valid_o   dump_addr_o / dump_data_o valid
//   dump_addr_o    linear address of dump_data_o
//   dump_data_o    dumped word
//
// Dump FSM
//   state   | meaning
//   S_IDLE  | cores arbitrate normally
//   S_SCAN  | core grants blocked, one linear word read per cycle
//   S_FLUSH | last dumped word is on the outputs, then back to idle
module sh_mem_rr #(
  parameter int NUM_CORES   = 4,
  parameter int NUM_BANKS   = 4,
  parameter int DATA_W      = 8,
  parameter int WORD_ADDR_W = 8,
  localparam int BANK_ID_W  = $clog2(NUM_BANKS),
  localparam int ADDR_W     = BANK_ID_W + WORD_ADDR_W
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [2*NUM_CORES-1:0]        enable_i,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr_i,
  input  logic [NUM_CORES*DATA_W-1:0]   wr_data_i,
  output logic [NUM_CORES*DATA_W-1:0]   rd_data_o,
  output logic [NUM_CORES-1:0]          ready_o,
  input  logic                          dump_start_i,
  output logic                          dump_busy_o,
  output logic                          dump_valid_o,
  output logic [ADDR_W-1:0]             dump_addr_o,
  output logic [DATA_W-1:0]             dump_data_o
);

  localparam int DEPTH     = 2 ** WORD_ADDR_W;
  localparam int MEM_WORDS = NUM_BANKS * DEPTH;
  localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     mem_q [MEM_WORDS];

  logic [1:0]            en_c   [NUM_CORES];
  logic [ADDR_W-1:0]     addr_c [NUM_CORES];
  logic [BANK_ID_W-1:0]  bank_c [NUM_CORES];
  logic [DATA_W-1:0]     wd_c   [NUM_CORES];
  logic [DATA_W-1:0]     rd_q   [NUM_CORES];

  logic [NUM_CORES-1:0]  req;
  logic [NUM_CORES-1:0]  gnt;
  logic [NUM_CORES-1:0]  gnt_wr;
  logic [NUM_CORES-1:0]  gnt_rd;
  logic [NUM_CORES-1:0]  rd_pend_q;
  logic [CORE_W-1:0]     ptr_q [NUM_BANKS];
  logic [CORE_W-1:0]     ptr_d [NUM_BANKS];

  logic                  dump_valid_q;
  logic [ADDR_W-1:0]     dump_addr_q;
  logic [DATA_W-1:0]     dump_data_q;

  // A core whose read completes this cycle is masked so the still-held
  // request is not granted a second time. Grants are also blocked while
  // reset is asserted so ready stays low during reset.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      en_c[c]   = enable_i[2*c +: 2];
      addr_c[c] = addr_i[c*ADDR_W +: ADDR_W];
      bank_c[c] = addr_c[c][ADDR_W-1 -: BANK_ID_W];
      wd_c[c]   = wr_data_i[c*DATA_W +: DATA_W];
      req[c]    = (en_c[c] != 2'b00) && !rd_pend_q[c] &&
                  (state_q == S_IDLE) && !reset_i;
    end
  end

  // Per bank: scan cores starting after the last granted one.
  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ptr_d[b] = ptr_q[b];
      found    = 1'b0;
      for (int i = 1; i <= NUM_CORES; i++) begin
        idx = (int'(ptr_q[b]) + i) % NUM_CORES;
        if (!found && req[idx] && (bank_c[idx] == BANK_ID_W'(b))) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d[b] = CORE_W'(idx);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      gnt_wr[c] = gnt[c] & en_c[c][1];
      gnt_rd[c] = gnt[c] & (en_c[c] == 2'b01);
      ready_o[c] = gnt_wr[c] | rd_pend_q[c];
      rd_data_o[c*DATA_W +: DATA_W] = rd_pend_q[c] ? rd_q[c] : '0;
    end
  end

  // Storage is not reset; contents survive reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if (gnt_wr[c]) mem_q[addr_c[c]] <= wd_c[c];
      if (gnt_rd[c]) rd_q[c]          <= mem_q[addr_c[c]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start_i) begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end
      end
      S_SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_pend_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= CORE_W'(NUM_CORES - 1);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= gnt_rd;
      dump_valid_q <= (state_q == S_SCAN);
      if (state_q == S_SCAN) begin
        dump_addr_q <= cnt_q;
        dump_data_q <= mem_q[cnt_q];
      end
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= ptr_d[b];
    end
  end

  assign dump_busy_o  = (state_q != S_IDLE);
  assign dump_valid_o = dump_valid_q;
  assign dump_addr_o  = dump_addr_q;
  assign dump_data_o  = dump_data_q;

endmodule

// File: tb/tb_sh_mem_rr.sv
// Directed bench for sh_mem_rr with default parameters (4 cores, 4 banks,
// 8-bit data, 256 words per bank).
module tb_sh_mem_rr;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int AW = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [2*NC-1:0]  enable;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wr_data;
  logic [NC*DW-1:0] rd_data;
  logic [NC-1:0]    ready;
  logic             dump_start;
  logic             dump_busy;
  logic             dump_valid;
  logic [AW-1:0]    dump_addr;
  logic [DW-1:0]    dump_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sh_mem_rr dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .addr_i       (addr),
    .wr_data_i    (wr_data),
    .rd_data_o    (rd_data),
    .ready_o      (ready),
    .dump_start_i (dump_start),
    .dump_busy_o  (dump_busy),
    .dump_valid_o (dump_valid),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk(input int b, input int w);
    return AW'(b * 256 + w);
  endfunction

  function automatic logic [DW-1:0] rdc(input int c);
    return rd_data[c*DW +: DW];
  endfunction

  task automatic set_req(input int c, input logic [1:0] en, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    enable[2*c +: 2]  = en;
    addr[c*AW +: AW]  = a;
    wr_data[c*DW +: DW] = d;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    set_req(c, 2'b10, a, d);
    @(negedge clk);
    while (!ready[c] && n < 16) begin
      next_cyc();
      @(negedge clk);
      n++;
    end
    check("wr_timeout", 32'(n < 16), 32'd1);
    next_cyc();
    set_req(c, 2'b00, '0, '0);
  endtask

  task automatic do_read(input string tag, input int c, input logic [AW-1:0] a,
                         input logic [DW-1:0] exp);
    int n;
    n = 0;
    set_req(c, 2'b01, a, '0);
    @(negedge clk);
    while (!ready[c] && n < 16) begin
      next_cyc();
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 16), 32'd1);
    check(tag, rdc(c), exp);
    next_cyc();
    set_req(c, 2'b00, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, leak, busy_bad, vcnt;
    reset      = 1'b1;
    enable     = '0;
    addr       = '0;
    wr_data    = '0;
    dump_start = 1'b0;
    #12;
    check("rst_ready", ready, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_daddr", dump_addr, 0);
    check("rst_ddata", dump_data, 0);
    #11;
    reset = 1'b0;
    next_cyc();

    // single write then read, bank 1 word 5
    set_req(0, 2'b10, mk(1, 5), 8'hA5);
    @(negedge clk);
    check("t1_wr_ready", ready, 4'b0001);
    next_cyc();
    set_req(0, 2'b01, mk(1, 5), 8'h00);
    @(negedge clk);
    check("t1_rd_grant_cycle", ready, 4'b0000);
    next_cyc();
    @(negedge clk);
    check("t1_rd_ready", ready, 4'b0001);
    check("t1_rd_data", rdc(0), 8'hA5);
    check("t1_rd_others", rd_data[NC*DW-1:DW], 0);
    next_cyc();
    set_req(0, 2'b00, '0, '0);
    next_cyc();

    // four cores contend for bank 2
    for (int c = 0; c < NC; c++) set_req(c, 2'b10, mk(2, c), 8'(8'h10 + c));
    for (int k = 0; k < NC; k++) begin
      @(negedge clk);
      check("t2_grant_order", ready, 32'(1 << k));
      next_cyc();
      set_req(k, 2'b00, '0, '0);
    end
    for (int k = 0; k < NC; k++) do_read("t2_readback", 0, mk(2, k), 8'(8'h10 + k));

    // cores 0 and 3 hold reads on bank 0
    do_write(0, mk(0, 7), 8'h77);
    do_write(3, mk(0, 8), 8'h88);
    set_req(0, 2'b01, mk(0, 7), '0);
    set_req(3, 2'b01, mk(0, 8), '0);
    @(negedge clk);
    check("t3_first_cycle", ready, 0);
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      @(negedge clk);
      if (k % 2 == 1) begin
        check("t3_alt_ready", ready, 4'b0001);
        check("t3_alt_data0", rdc(0), 8'h77);
      end else begin
        check("t3_alt_ready", ready, 4'b1000);
        check("t3_alt_data3", rdc(3), 8'h88);
      end
    end
    next_cyc();
    set_req(0, 2'b00, '0, '0);
    set_req(3, 2'b00, '0, '0);
    next_cyc();
    next_cyc();

    // four cores read four different banks at once
    for (int c = 0; c < NC; c++) do_write(c, mk(c, 8'h20), 8'(8'h30 + c));
    for (int c = 0; c < NC; c++) set_req(c, 2'b01, mk(c, 8'h20), '0);
    @(negedge clk);
    check("t4_grant_cycle", ready, 0);
    next_cyc();
    @(negedge clk);
    check("t4_all_ready", ready, 4'b1111);
    for (int c = 0; c < NC; c++) check("t4_data", rdc(c), 8'(8'h30 + c));
    next_cyc();
    for (int c = 0; c < NC; c++) set_req(c, 2'b00, '0, '0);
    next_cyc();

    // preload image word ^ 0x5A, one bank per core in parallel
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      for (int c = 0; c < NC; c++) set_req(c, 2'b10, mk(c, w), 8'(w) ^ 8'h5A);
      @(negedge clk);
      if (ready !== 4'b1111) bad++;
      next_cyc();
    end
    for (int c = 0; c < NC; c++) set_req(c, 2'b00, '0, '0);
    check("preload_ready_bad", bad, 0);
    next_cyc();

    // full dump with a write from core 1 held throughout
    dump_start = 1'b1;
    @(negedge clk);
    check("dump_idle_before", dump_busy, 0);
    next_cyc();
    dump_start = 1'b0;
    set_req(1, 2'b10, mk(3, 0), 8'hEE);
    bad = 0; leak = 0; busy_bad = 0; vcnt = 0;
    for (int k = 0; k <= 1024; k++) begin
      @(negedge clk);
      if (dump_busy !== 1'b1) busy_bad++;
      if (ready !== 4'b0000) leak++;
      if (dump_valid !== (k >= 1)) bad++;
      if (dump_valid === 1'b1) begin
        vcnt++;
        if (dump_addr !== AW'(k - 1)) bad++;
        if (dump_data !== (8'(k - 1) ^ 8'h5A)) bad++;
      end
      next_cyc();
    end
    check("dump_valid_count", vcnt, 1024);
    check("dump_seq_bad", bad, 0);
    check("dump_busy_bad", busy_bad, 0);
    check("dump_ready_leak", leak, 0);
    @(negedge clk);
    check("dump_busy_end", dump_busy, 0);
    check("dump_valid_end", dump_valid, 0);
    check("dump_held_wr", ready, 4'b0010);
    next_cyc();
    set_req(1, 2'b00, '0, '0);
    next_cyc();

    // read granted with dump_start, then async reset mid-scan
    dump_start = 1'b1;
    set_req(2, 2'b01, mk(2, 8'h10), '0);
    @(negedge clk);
    check("t6_grant_cycle", ready, 0);
    next_cyc();
    dump_start = 1'b0;
    @(negedge clk);
    check("t6_scan_busy", dump_busy, 1);
    check("t6_pre_read_rdy", ready, 4'b0100);
    check("t6_pre_read_data", rdc(2), 8'h10 ^ 8'h5A);
    next_cyc();
    set_req(2, 2'b00, '0, '0);
    repeat (50) next_cyc();
    #2;
    reset = 1'b1;
    set_req(0, 2'b10, mk(0, 8'h33), 8'h99);
    #1;
    check("ar_busy", dump_busy, 0);
    check("ar_valid", dump_valid, 0);
    check("ar_daddr", dump_addr, 0);
    check("ar_ddata", dump_data, 0);
    check("ar_ready", ready, 0);
    check("ar_rd_data", rd_data, 0);
    @(posedge clk);
    #3;
    set_req(0, 2'b00, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    next_cyc();
    check("ar_idle_after", dump_busy, 0);
    do_read("ar_read_ee", 0, mk(3, 0), 8'hEE);
    do_read("ar_read_nowr", 1, mk(0, 8'h33), 8'h33 ^ 8'h5A);
    do_read("ar_read_img", 2, mk(1, 5), 8'h05 ^ 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
